// File: rtl/disp_pkg.sv
// Shared types and helpers for the 4-digit multiplexed 7-segment scanner.
package disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dots;
        logic [3:0]  blank;
    } disp_frame_t;

    function automatic logic [3:0] nibble(input logic [15:0] v, input digit_idx_t i);
        logic [15:0] s;
        s = v >> {i, 2'b00};
        return s[3:0];
    endfunction

    // Bit i set when digit i and every more-significant digit are zero; digit 0 always shown.
    function automatic logic [3:0] lz_mask(input logic [15:0] v);
        logic [3:0] m;
        m[3] = (v[15:12] == 4'h0);
        m[2] = (v[15:8]  == 8'h00);
        m[1] = (v[15:4]  == 12'h000);
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// Slot prescaler: free-running 0..SCAN_TICKS-1 count with a tick on the last cycle of each slot.
module disp_tick_gen #(
    parameter int SCAN_TICKS = 100000,
    parameter int CNT_W      = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             tick_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    always_comb begin
        tick  = (cnt_q == CNT_W'(SCAN_TICKS - 1));
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = tick;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 4-digit scanner feeding a hex-to-7-segment decoder, with tear-free
// frame-boundary updates, blanking, leading-zero suppression and anti-ghosting gaps.
module disp_scan_mux
    import disp_pkg::*;
#(
    parameter int SCAN_TICKS   = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  dots,
    input  logic [3:0]  blank_mask,
    input  logic        lz_suppress,
    output logic [3:0]  hex,
    output logic        point,
    output logic        le,
    output logic [3:0]  an,
    output logic        upd_ack
);

    localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

    logic             tick;
    logic [CNT_W-1:0] slot_cnt;

    disp_tick_gen #(
        .SCAN_TICKS (SCAN_TICKS),
        .CNT_W      (CNT_W)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (tick),
        .cnt_o  (slot_cnt)
    );

    digit_idx_t  idx_q, idx_d;
    disp_frame_t shown_q, shown_d;
    disp_frame_t pend_q, pend_d;
    logic        pvld_q, pvld_d;
    logic        ack_q, ack_d;
    logic [3:0]  hex_q, hex_d;
    logic        point_q, point_d;
    logic        le_q, le_d;
    logic [3:0]  an_q, an_d;

    logic        boundary;
    logic        in_blank;
    logic        dark;
    logic [3:0]  lzm;
    disp_frame_t in_frame;

    always_comb begin
        idx_d    = idx_q;
        shown_d  = shown_q;
        pend_d   = pend_q;
        pvld_d   = pvld_q;
        ack_d    = 1'b0;
        in_frame = '{value: value, dots: dots, blank: blank_mask};
        boundary = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

        if (tick) begin
            idx_d = idx_q + 1'b1;
        end

        if (load) begin
            pend_d = in_frame;
            pvld_d = 1'b1;
        end

        // A load on the boundary cycle bypasses pending and is shown directly.
        if (boundary) begin
            pvld_d = 1'b0;
            if (load) begin
                shown_d = in_frame;
                ack_d   = 1'b1;
            end else if (pvld_q) begin
                shown_d = pend_q;
                ack_d   = 1'b1;
            end
        end
    end

    always_comb begin
        in_blank = (slot_cnt < CNT_W'(BLANK_CYCLES));
        lzm      = lz_suppress ? lz_mask(shown_q.value) : 4'b0000;
        dark     = shown_q.blank[idx_q] | lzm[idx_q] | in_blank;
        an_d     = in_blank ? AN_ALL_OFF : ~(4'b0001 << idx_q);
        hex_d    = nibble(shown_q.value, idx_q);
        le_d     = dark;
        point_d  = dark | ~shown_q.dots[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shown_q <= '0;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            ack_q   <= 1'b0;
            hex_q   <= 4'h0;
            point_q <= 1'b1;
            le_q    <= 1'b1;
            an_q    <= AN_ALL_OFF;
        end else begin
            idx_q   <= idx_d;
            shown_q <= shown_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            ack_q   <= ack_d;
            hex_q   <= hex_d;
            point_q <= point_d;
            le_q    <= le_d;
            an_q    <= an_d;
        end
    end

    assign hex     = hex_q;
    assign point   = point_q;
    assign le      = le_q;
    assign an      = an_q;
    assign upd_ack = ack_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed + randomized bench for disp_scan_mux against a frame-arithmetic reference model.
module tb_disp_scan_mux;

    localparam int N = 8;
    localparam int B = 2;
    localparam int FRAME = 4 * N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  blank_mask;
    logic        lz_suppress;
    logic [3:0]  hex;
    logic        point;
    logic        le;
    logic [3:0]  an;
    logic        upd_ack;

    int errors = 0;
    int checks = 0;
    int acks   = 0;

    disp_scan_mux #(
        .SCAN_TICKS   (N),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .dots        (dots),
        .blank_mask  (blank_mask),
        .lz_suppress (lz_suppress),
        .hex         (hex),
        .point       (point),
        .le          (le),
        .an          (an),
        .upd_ack     (upd_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] hex;
        logic       point;
        logic       le;
        logic [3:0] an;
    } exp_t;

    localparam exp_t RESET_EXP = '{hex: 4'h0, point: 1'b1, le: 1'b1, an: 4'hF};

    // Reference: edges since reset e gives slot = e mod N, digit = (e / N) mod 4.
    function automatic exp_t predict(input int e, input logic [15:0] v, input logic [3:0] d,
                                     input logic [3:0] m, input logic lz);
        int   slot;
        int   dig;
        logic dark;
        exp_t r;
        slot    = e % N;
        dig     = (e / N) % 4;
        dark    = m[dig] || (slot < B) || (lz && dig != 0 && (v >> (4 * dig)) == 16'h0);
        r.hex   = 4'(v >> (4 * dig));
        r.le    = dark;
        r.point = dark || !d[dig];
        r.an    = (slot < B) ? 4'hF : ~(4'b0001 << dig);
        return r;
    endfunction

    int          j = 0;
    logic [15:0] m_val = '0, p_val = '0;
    logic [3:0]  m_dots = '0, m_mask = '0, p_dots = '0, p_mask = '0;
    logic        p_vld = 1'b0;
    exp_t        exp_o = RESET_EXP;
    logic        exp_ack = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j       <= 0;
            m_val   <= '0;
            m_dots  <= '0;
            m_mask  <= '0;
            p_val   <= '0;
            p_dots  <= '0;
            p_mask  <= '0;
            p_vld   <= 1'b0;
            exp_o   <= RESET_EXP;
            exp_ack <= 1'b0;
        end else begin
            exp_o   <= predict(j, m_val, m_dots, m_mask, lz_suppress);
            j       <= j + 1;
            exp_ack <= 1'b0;
            if ((j + 1) % FRAME == 0) begin
                p_vld <= 1'b0;
                if (load) begin
                    m_val <= value; m_dots <= dots; m_mask <= blank_mask;
                    exp_ack <= 1'b1;
                end else if (p_vld) begin
                    m_val <= p_val; m_dots <= p_dots; m_mask <= p_mask;
                    exp_ack <= 1'b1;
                end
            end else if (load) begin
                p_val <= value; p_dots <= dots; p_mask <= blank_mask;
                p_vld <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("an", 32'(an), 32'(exp_o.an));
            chk("hex", 32'(hex), 32'(exp_o.hex));
            chk("le", 32'(le), 32'(exp_o.le));
            chk("point", 32'(point), 32'(exp_o.point));
            chk("upd_ack", 32'(upd_ack), 32'(exp_ack));
            if (upd_ack === 1'b1) acks++;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hex"}, 32'(hex), 32'h0);
        chk({tag, "_point"}, 32'(point), 32'h1);
        chk({tag, "_le"}, 32'(le), 32'h1);
        chk({tag, "_an"}, 32'(an), 32'hF);
        chk({tag, "_ack"}, 32'(upd_ack), 32'h0);
    endtask

    // Advance until the next edge is edge (frame_pos) within a frame; bounded by one frame.
    task automatic goto_pos(input int frame_pos);
        for (int k = 0; k < FRAME && (j % FRAME) != frame_pos; k++) step(1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] m);
        value = v; dots = d; blank_mask = m; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; value = '0; dots = '0; blank_mask = '0; lz_suppress = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Idle scanning after reset.
        acks = 0;
        step(2 * FRAME);
        chk("idle_acks", 32'(acks), 32'd0);

        // Single load becomes visible at the next frame boundary.
        acks = 0;
        do_load(16'h1A3F, 4'b0100, 4'b0000);
        step(2 * FRAME + 2);
        chk("load_acks", 32'(acks), 32'd1);
        chk("shown_val", 32'(m_val), 32'h1A3F);

        // Two loads in one frame: latest wins, single ack.
        goto_pos(0);
        acks = 0;
        do_load(16'h1111, 4'b0000, 4'b0000);
        step(3);
        do_load(16'h2222, 4'b0000, 4'b0000);
        step(2 * FRAME);
        chk("dbl_acks", 32'(acks), 32'd1);

        // Load on the boundary cycle itself.
        goto_pos(FRAME - 1);
        acks = 0;
        do_load(16'h7E81, 4'b1001, 4'b0000);
        step(FRAME + 2);
        chk("bnd_acks", 32'(acks), 32'd1);

        // Leading-zero suppression on and off.
        lz_suppress = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        step(2 * FRAME + 2);
        lz_suppress = 1'b0;
        step(FRAME);

        // Forced-dark digit 3 with all dots requested.
        do_load(16'h9876, 4'b1111, 4'b1000);
        step(2 * FRAME + 2);

        // Async reset mid-slot of digit 2 with a pending load.
        goto_pos(0);
        do_load(16'hBEEF, 4'b0011, 4'b0000);
        goto_pos(2 * N + 4);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        step(2);
        rst_n = 1'b1;
        acks = 0;
        step(2 * FRAME);
        chk("post_rst_acks", 32'(acks), 32'd0);
        chk("post_rst_val", 32'(m_val), 32'h0);

        // Randomized loads, masks and suppression.
        for (int k = 0; k < 600; k++) begin
            load        = ($urandom_range(0, 7) == 0);
            value       = 16'($urandom);
            if ($urandom_range(0, 1) == 1) value = value & 16'h00FF;
            dots        = 4'($urandom);
            blank_mask  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 31) == 0) lz_suppress = ~lz_suppress;
            step(1);
        end
        load = 1'b0;
        step(2 * FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
